// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the memory-stage load/store unit.
//   - funct3 load/store size codes and the internal access-size decode
//   - NOP_INSTR: canonical bubble instruction (addi x0, x0, 0)
//   - lsu_state_t: LSU bus FSM states
//   - WB_*: write-back select encodings
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } mem_size_t;

  // Unlisted funct3 codes fall back to a full-word access.
  function automatic mem_size_t decode_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the memory stage.
// Ports:
//   funct3      in   3  access size / signedness
//   byte_off    in   2  effective address bits [1:0]
//   store_data  in  32  register value to be stored
//   rdata       in  32  word returned by the data bus
//   wdata       out 32  store data replicated across the lanes
//   wstrb       out  4  byte strobes for the store
//   load_data   out 32  selected and sign/zero-extended load result
//   misaligned  out  1  halfword on odd address or word not on a 4-byte boundary
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data,
  output logic        misaligned
);

  mem_size_t   size;
  logic        zero_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign size     = decode_size(funct3);
  assign zero_ext = funct3[2];
  assign ld_byte  = rdata[{byte_off, 3'b000} +: 8];
  assign ld_half  = byte_off[1] ? rdata[31:16] : rdata[15:0];

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    wdata      = store_data;
    wstrb      = 4'b1111;
    load_data  = rdata;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        wdata     = {4{store_data[7:0]}};
        wstrb     = 4'b0001 << byte_off;
        load_data = zero_ext ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_H: begin
        wdata      = {2{store_data[15:0]}};
        wstrb      = 4'b0011 << {byte_off[1], 1'b0};
        load_data  = zero_ext ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
        misaligned = byte_off[0];
      end
      default: begin
        misaligned = |byte_off;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory stage of the five-stage pipeline.
// Issues one outstanding req/ready data-bus access per load/store, stalls the
// front of the pipeline while it is in flight and registers MEM/WB.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   EX_MEM_*                          EX/MEM pipeline register fields (held while stall=1)
//   mem_req/we/addr/wdata/wstrb       registered bus request, constant while mem_req=1
//   mem_rdata, mem_ready              bus response
//   stall                             combinational pipeline hold
//   MEM_WB_*                          MEM/WB pipeline register fields
//   misalign, bus_err                 one-cycle exception pulses
// Parameter WAIT_LIMIT (1..255): BUSY cycles without mem_ready before abort.
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] EX_MEM_PC,
  input  logic [31:0] EX_MEM_ALU_Result,
  input  logic [31:0] EX_MEM_RD2,
  input  logic [31:0] EX_MEM_Instr,
  input  logic [1:0]  EX_MEM_WBSel,
  input  logic        EX_MEM_RegWEn,
  input  logic        EX_MEM_MemR,
  input  logic        EX_MEM_MemW,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic [31:0] MEM_WB_PC,
  output logic [31:0] MEM_WB_ALU_Result,
  output logic [31:0] MEM_WB_RData,
  output logic [31:0] MEM_WB_Instr,
  output logic [1:0]  MEM_WB_WBSel,
  output logic        MEM_WB_RegWEn,
  output logic        misalign,
  output logic        bus_err
);

  // Abort fires on the WAIT_LIMIT-th BUSY cycle that has no mem_ready.
  localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

  lsu_state_t  state, state_nxt;
  logic [7:0]  wait_cnt;
  logic        access, misaligned, misalign_hit;
  logic        issue, complete, abort, stall_int;
  logic [31:0] wdata, load_data;
  logic [3:0]  wstrb;

  assign access = EX_MEM_MemR | EX_MEM_MemW;

  lsu_align u_align (
    .funct3     (EX_MEM_Instr[14:12]),
    .byte_off   (EX_MEM_ALU_Result[1:0]),
    .store_data (EX_MEM_RD2),
    .rdata      (mem_rdata),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  always_comb begin
    state_nxt    = state;
    issue        = 1'b0;
    complete     = 1'b0;
    abort        = 1'b0;
    stall_int    = 1'b0;
    misalign_hit = 1'b0;
    case (state)
      IDLE: begin
        if (access && misaligned) begin
          misalign_hit = 1'b1;
        end else if (access) begin
          issue     = 1'b1;
          stall_int = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A response on the last allowed cycle still wins over the abort.
        if (mem_ready) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall_int = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // While reset is asserted the FSM is forced to IDLE, but a load/store may
  // still be sitting in EX/MEM; mask stall so every output reads 0 in reset.
  assign stall = stall_int & rst_n;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      mem_req           <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      mem_wstrb         <= '0;
      MEM_WB_PC         <= '0;
      MEM_WB_ALU_Result <= '0;
      MEM_WB_RData      <= '0;
      MEM_WB_Instr      <= '0;
      MEM_WB_WBSel      <= '0;
      MEM_WB_RegWEn     <= 1'b0;
      misalign          <= 1'b0;
      bus_err           <= 1'b0;
    end else begin
      state    <= state_nxt;
      misalign <= misalign_hit;
      bus_err  <= abort;

      if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= EX_MEM_MemW;
        mem_addr  <= {EX_MEM_ALU_Result[31:2], 2'b00};
        mem_wdata <= wdata;
        mem_wstrb <= EX_MEM_MemW ? wstrb : 4'b0000;
        wait_cnt  <= '0;
      end else if (complete || abort) begin
        mem_req <= 1'b0;
      end else if (state == BUSY) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (stall_int) begin
        MEM_WB_PC         <= '0;
        MEM_WB_ALU_Result <= '0;
        MEM_WB_RData      <= '0;
        MEM_WB_Instr      <= NOP_INSTR;
        MEM_WB_WBSel      <= WB_ALU;
        MEM_WB_RegWEn     <= 1'b0;
      end else begin
        MEM_WB_PC         <= EX_MEM_PC;
        MEM_WB_ALU_Result <= EX_MEM_ALU_Result;
        MEM_WB_Instr      <= EX_MEM_Instr;
        MEM_WB_WBSel      <= EX_MEM_WBSel;
        MEM_WB_RegWEn     <= EX_MEM_RegWEn & ~misalign_hit & ~abort;
        // MemW has priority, so only a pure load returns data.
        MEM_WB_RData      <= (complete && !EX_MEM_MemW) ? load_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed, scoreboarded bench for mem_stage_lsu with WAIT_LIMIT=4.
module tb_mem_stage_lsu;
  import riscv_pkg::*;

  localparam int unsigned WL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] EX_MEM_PC, EX_MEM_ALU_Result, EX_MEM_RD2, EX_MEM_Instr;
  logic [1:0]  EX_MEM_WBSel;
  logic        EX_MEM_RegWEn, EX_MEM_MemR, EX_MEM_MemW;
  logic        mem_req, mem_we, mem_ready, stall, misalign, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] MEM_WB_PC, MEM_WB_ALU_Result, MEM_WB_RData, MEM_WB_Instr;
  logic [1:0]  MEM_WB_WBSel;
  logic        MEM_WB_RegWEn;

  always #5 clk = ~clk;

  mem_stage_lsu #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst_n(rst_n),
    .EX_MEM_PC(EX_MEM_PC), .EX_MEM_ALU_Result(EX_MEM_ALU_Result),
    .EX_MEM_RD2(EX_MEM_RD2), .EX_MEM_Instr(EX_MEM_Instr),
    .EX_MEM_WBSel(EX_MEM_WBSel), .EX_MEM_RegWEn(EX_MEM_RegWEn),
    .EX_MEM_MemR(EX_MEM_MemR), .EX_MEM_MemW(EX_MEM_MemW),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
    .MEM_WB_PC(MEM_WB_PC), .MEM_WB_ALU_Result(MEM_WB_ALU_Result),
    .MEM_WB_RData(MEM_WB_RData), .MEM_WB_Instr(MEM_WB_Instr),
    .MEM_WB_WBSel(MEM_WB_WBSel), .MEM_WB_RegWEn(MEM_WB_RegWEn),
    .misalign(misalign), .bus_err(bus_err)
  );

  typedef struct {
    logic [31:0] pc, alu, rdata, instr;
    logic [1:0]  wbsel;
    logic        regwen;
  } wb_t;

  wb_t         sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_we;
  bit          saw_req;
  int          stalls;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc);
    return {17'h0, f3, 5'd2, opc};
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] f3, input logic [1:0] a);
    if (f3 == 3'b001 || f3 == 3'b101) return a[0];
    if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
    return a != 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic pop_check(input string tag);
    wb_t e;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, ".pc"},     MEM_WB_PC, e.pc);
    check({tag, ".alu"},    MEM_WB_ALU_Result, e.alu);
    check({tag, ".rdata"},  MEM_WB_RData, e.rdata);
    check({tag, ".instr"},  MEM_WB_Instr, e.instr);
    check({tag, ".wbsel"},  {30'b0, MEM_WB_WBSel}, {30'b0, e.wbsel});
    check({tag, ".regwen"}, {31'b0, MEM_WB_RegWEn}, {31'b0, e.regwen});
  endtask

  // Drives one EX/MEM instruction and holds it until stall drops.
  // ready_on: BUSY cycle (1-based) on which mem_ready is returned; 0 = never.
  task automatic run_op(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                        input logic [31:0] rd2, input logic [31:0] instr,
                        input logic [1:0] wbsel, input logic regwen,
                        input logic memr, input logic memw,
                        input int ready_on, input logic [31:0] rword);
    wb_t  e;
    logic misal, acc, st;
    int   busy;
    bit   done;
    EX_MEM_PC = pc; EX_MEM_ALU_Result = addr; EX_MEM_RD2 = rd2; EX_MEM_Instr = instr;
    EX_MEM_WBSel = wbsel; EX_MEM_RegWEn = regwen; EX_MEM_MemR = memr; EX_MEM_MemW = memw;
    mem_ready = 1'b0;
    acc   = memr | memw;
    misal = acc && ref_misaligned(instr[14:12], addr[1:0]);
    e.pc = pc; e.alu = addr; e.instr = instr; e.wbsel = wbsel;
    e.regwen = regwen && !misal && !(acc && ready_on == 0);
    e.rdata  = (memr && !memw && !misal && ready_on != 0) ?
               ref_load(instr[14:12], addr[1:0], rword) : 32'h0;
    sb_q.push_back(e);
    check({tag, ".req_low_at_start"}, {31'b0, mem_req}, 32'd0);
    stalls = 0; busy = 0; saw_req = 0; done = 0;
    for (int g = 0; g < 40 && !done; g++) begin
      if (mem_req) begin
        busy++;
        if (!saw_req) begin
          saw_req = 1; bus_addr = mem_addr; bus_wdata = mem_wdata;
          bus_wstrb = mem_wstrb; bus_we = mem_we;
        end else begin
          check({tag, ".addr_hold"}, mem_addr, bus_addr);
          check({tag, ".wstrb_hold"}, {28'b0, mem_wstrb}, {28'b0, bus_wstrb});
        end
        mem_ready = (busy == ready_on);
        mem_rdata = mem_ready ? rword : 32'h5A5A_5A5A;
      end else begin
        mem_ready = 1'b0;
      end
      @(negedge clk);
      st = stall;
      stalls += int'(st);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (st) begin
        check({tag, ".bubble_instr"}, MEM_WB_Instr, NOP_INSTR);
        check({tag, ".bubble_regwen"}, {31'b0, MEM_WB_RegWEn}, 32'd0);
      end else begin
        pop_check(tag);
        done = 1;
      end
    end
    if (!done) check({tag, ".timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    EX_MEM_PC = '0; EX_MEM_ALU_Result = '0; EX_MEM_RD2 = '0; EX_MEM_Instr = '0;
    EX_MEM_WBSel = '0; EX_MEM_RegWEn = 1'b0; EX_MEM_MemR = 1'b0; EX_MEM_MemW = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;

    #12;
    check("rst.mem_req", {31'b0, mem_req}, 32'd0);
    check("rst.stall", {31'b0, stall}, 32'd0);
    check("rst.instr", MEM_WB_Instr, 32'd0);
    check("rst.regwen", {31'b0, MEM_WB_RegWEn}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // SW 0x104, ready on first BUSY cycle
    run_op("sw", 32'h100, 32'h104, 32'hDEAD_BEEF, mk(F3_W, 7'h23), WB_ALU, 1'b0, 1'b0, 1'b1,
           1, 32'h0);
    check("sw.stalls", stalls, 32'd1);
    check("sw.addr", bus_addr, 32'h104);
    check("sw.wstrb", {28'b0, bus_wstrb}, 32'hF);
    check("sw.wdata", bus_wdata, 32'hDEAD_BEEF);
    check("sw.we", {31'b0, bus_we}, 32'd1);

    // LB 0x203, ready on third BUSY cycle; ADD in between; LBU same word
    run_op("lb", 32'h104, 32'h203, 32'h0, mk(F3_B, 7'h03), WB_MEM, 1'b1, 1'b1, 1'b0,
           3, 32'h80FF_FFFF);
    check("lb.stalls", stalls, 32'd3);
    check("lb.rdata", MEM_WB_RData, 32'hFFFF_FF80);
    check("lb.addr", bus_addr, 32'h200);
    check("lb.we", {31'b0, bus_we}, 32'd0);
    run_op("add", 32'h108, 32'h1234, 32'h0, 32'h0020_8133, WB_ALU, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    check("add.stalls", stalls, 32'd0);
    run_op("lbu", 32'h10C, 32'h203, 32'h0, mk(F3_BU, 7'h03), WB_MEM, 1'b1, 1'b1, 1'b0,
           1, 32'h80FF_FFFF);
    check("lbu.rdata", MEM_WB_RData, 32'h0000_0080);

    // Misaligned LH: no bus cycle, no stall, one-cycle misalign pulse
    run_op("lh_mis", 32'h110, 32'h201, 32'h0, mk(F3_H, 7'h03), WB_MEM, 1'b1, 1'b1, 1'b0,
           1, 32'h0);
    check("lh_mis.stalls", stalls, 32'd0);
    check("lh_mis.no_req", {31'b0, saw_req}, 32'd0);
    check("lh_mis.pulse", {31'b0, misalign}, 32'd1);
    run_op("nop1", 32'h114, 32'h0, 32'h0, NOP_INSTR, WB_ALU, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    check("nop1.misalign_low", {31'b0, misalign}, 32'd0);

    // LW with no ready: abort after WAIT_LIMIT
    run_op("lw_abort", 32'h118, 32'h300, 32'h0, mk(F3_W, 7'h03), WB_MEM, 1'b1, 1'b1, 1'b0,
           0, 32'h0);
    check("lw_abort.stalls", stalls, WL);
    check("lw_abort.bus_err", {31'b0, bus_err}, 32'd1);
    check("lw_abort.req_low", {31'b0, mem_req}, 32'd0);
    run_op("add2", 32'h11C, 32'h55, 32'h0, 32'h0020_8133, WB_ALU, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    check("add2.bus_err_low", {31'b0, bus_err}, 32'd0);

    // SB 0x7, halfword loads, store priority when MemR and MemW are both set
    run_op("sb", 32'h120, 32'h7, 32'h12, mk(F3_B, 7'h23), WB_ALU, 1'b0, 1'b0, 1'b1, 2, 32'h0);
    check("sb.wdata", bus_wdata, 32'h1212_1212);
    check("sb.wstrb", {28'b0, bus_wstrb}, 32'h8);
    check("sb.addr", bus_addr, 32'h4);
    run_op("lhu", 32'h124, 32'h202, 32'h0, mk(F3_HU, 7'h03), WB_MEM, 1'b1, 1'b1, 1'b0,
           1, 32'hBEEF_1234);
    check("lhu.rdata", MEM_WB_RData, 32'h0000_BEEF);
    run_op("lh", 32'h128, 32'h002, 32'h0, mk(F3_H, 7'h03), WB_MEM, 1'b1, 1'b1, 1'b0,
           2, 32'h8001_0000);
    check("lh.rdata", MEM_WB_RData, 32'hFFFF_8001);
    run_op("sh", 32'h12C, 32'h00A, 32'hCAFE_ABCD, mk(F3_H, 7'h23), WB_ALU, 1'b0, 1'b1, 1'b1,
           1, 32'hFFFF_FFFF);
    check("sh.we", {31'b0, bus_we}, 32'd1);
    check("sh.wstrb", {28'b0, bus_wstrb}, 32'hC);
    check("sh.wdata", bus_wdata, 32'hABCD_ABCD);

    // Reset in the middle of a BUSY access
    EX_MEM_PC = 32'h130; EX_MEM_ALU_Result = 32'h400; EX_MEM_Instr = mk(F3_W, 7'h03);
    EX_MEM_WBSel = WB_MEM; EX_MEM_RegWEn = 1'b1; EX_MEM_MemR = 1'b1; EX_MEM_MemW = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstb.req_busy", {31'b0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstb.req", {31'b0, mem_req}, 32'd0);
    check("rstb.stall", {31'b0, stall}, 32'd0);
    check("rstb.instr", MEM_WB_Instr, 32'd0);
    check("rstb.addr", mem_addr, 32'd0);
    EX_MEM_PC = '0; EX_MEM_ALU_Result = '0; EX_MEM_Instr = '0; EX_MEM_WBSel = '0;
    EX_MEM_RegWEn = 1'b0; EX_MEM_MemR = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("rstb.late_req", {31'b0, mem_req}, 32'd0);
    check("rstb.late_rdata", MEM_WB_RData, 32'd0);
    check("rstb.late_bus_err", {31'b0, bus_err}, 32'd0);
    check("rstb.late_stall", {31'b0, stall}, 32'd0);
    run_op("add3", 32'h134, 32'h77, 32'h0, 32'h0020_8133, WB_ALU, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit of the five-stage pipeline. Consumes the EX/MEM pipeline register outputs, performs byte/half/word loads and stores over a single-outstanding req/ready data-memory bus, and stalls the front of the pipeline while an access is in flight. Registers the MEM/WB pipeline register fields, including the sign/zero-extended load data.

## Interface
- WAIT_LIMIT, 15: max BUSY cycles without mem_ready before abort (1..255)
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- EX_MEM_PC / EX_MEM_ALU_Result / EX_MEM_RD2 / EX_MEM_Instr  in  32 each  PC, effective address, store data, instruction
- EX_MEM_WBSel  in  2  write-back select, passed through
- EX_MEM_RegWEn / EX_MEM_MemR / EX_MEM_MemW  in  1 each  reg write, load, store
- mem_req  out  1  bus request, held until mem_ready
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata / mem_wstrb  out  32 / 4  lane-replicated store data, byte strobes
- mem_rdata  in  32  read word, valid with mem_ready
- mem_ready  in  1  completes the current request
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM; EX_MEM_* must stay stable while high
- MEM_WB_PC / MEM_WB_ALU_Result / MEM_WB_RData / MEM_WB_Instr  out  32 each
- MEM_WB_WBSel  out  2;  MEM_WB_RegWEn  out  1
- misalign / bus_err  out  1 each  one-cycle exception pulses

## Operation
- Size from EX_MEM_Instr[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes with MemR/MemW are treated as W. MemW has priority if both MemR and MemW are set.
- Misaligned: H/HU with addr[0]=1, W with addr[1:0]≠0. No bus cycle. MEM/WB is written with RegWEn=0. misalign pulses for one cycle. No stall.
- Store lanes: SB wdata={4{rd2[7:0]}}, wstrb=0001<<addr[1:0]; SH wdata={2{rd2[15:0]}}, wstrb=0011<<{addr[1],1'b0}; SW wstrb=1111.
- Load extract: select byte/half by addr[1:0]; B/H sign-extend; BU/HU zero-extend; LW full word.
- FSM IDLE, BUSY:
  - IDLE, aligned access: stall=1; register mem_addr/we/wdata/wstrb; mem_req←1; →BUSY; MEM/WB ← bubble (RegWEn=0, WBSel=0, Instr=32'h00000013, others 0).
  - IDLE, no access: MEM/WB ← EX_MEM fields, RData=0; stall=0.
  - BUSY, mem_ready=1: stall=0; MEM/WB ← EX_MEM fields + extracted RData (stores: RData=0); mem_req←0; →IDLE.
  - BUSY, no ready, wait count <WAIT_LIMIT: stall=1; bubble; count+1.
  - BUSY, wait count reaches WAIT_LIMIT: abort; mem_req←0; bus_err pulse; MEM/WB with RegWEn=0; stall=0; →IDLE.
- Bus outputs stay constant while mem_req=1. mem_ready is ignored when mem_req=0.

## Timing
- Non-memory and misaligned instructions: 1-cycle EX/MEM→MEM/WB latency, no stall.
- Access with mem_ready on the k-th BUSY cycle (k≥1): stall high for k cycles; MEM/WB valid the edge after ready.
- Back-to-back accesses: a new request starts the cycle after IDLE is re-entered, with at least one mem_req-low cycle between requests.
- Reset (any time, including mid-BUSY): state IDLE, wait count 0, all outputs 0 (MEM_WB_Instr=0), mem_req=0 immediately. The outstanding request is dropped and a later mem_ready is ignored.
- stall is combinational from state, EX_MEM_MemR/MemW, alignment, mem_ready and count. All other outputs are registered.

## Structure
- Shared package riscv_pkg: funct3 size codes, NOP_INSTR=32'h00000013, lsu_state_t {IDLE,BUSY}, WBSel encodings.
- One combinational sub-module, lsu_align: store lane/strobe generation, load extract/extend, misalign detect.

## Test plan
- SW addr 0x104, rd2 0xDEADBEEF, ready on first BUSY cycle -> one stall cycle, mem_addr 0x104, wstrb 1111, MEM_WB_RegWEn 0.
- LB addr 0x203, rdata 0x80FF_FFFF, ready after 3 cycles -> stall 3 cycles, MEM_WB_RData 0xFFFFFF80; LBU gives 0x00000080.
- LH addr 0x201 -> no mem_req, misalign 1 cycle, MEM_WB_RegWEn 0, stall never high.
- WAIT_LIMIT=4, no ready -> stall 4 cycles, bus_err pulse, mem_req low, next instruction proceeds.
- SB addr 0x7 rd2 0x12 -> wdata 0x12121212, wstrb 1000; ADD between two loads -> ADD passes through with 1-cycle latency, RegWEn preserved.
- rst_n low during BUSY -> mem_req 0 at once, all outputs 0, IDLE after release, late mem_ready ignored.
